fetch_prefetch: RTL and testbench
=================================

Name: fetch_prefetch

Overview:
Parametrised instruction-fetch stage that decouples the core from memory latency. It issues sequential fetch requests over a valid/ready request channel and accepts in-order responses, up to DEPTH in flight. Responses are buffered in a DEPTH-entry FIFO, and one instruction per cycle is presented to decode. Redirects from writeback (trap, mret) and memory (branch) flush the buffer and discard stale in-flight responses.

Parameters:
XLEN, 32, address and instruction width.
DEPTH, 4, FIFO entries and maximum outstanding requests; must be a power of 2 and at least 2.
RESET_VECTOR, 0, PC loaded on reset.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  synchronous, active-low reset; reset==0 at a rising edge resets the block.
branch  in  1  redirect from memory stage.
branch_vector  in  XLEN  branch target.
trap  in  1  redirect from writeback to trap_vector.
mret  in  1  redirect from writeback to mret_vector.
trap_vector  in  XLEN  trap target, from csr.
mret_vector  in  XLEN  mret target, from csr.
stall  in  1  hazard unit: hold the decode outputs.
invalidate  in  1  hazard unit: send a bubble to decode.
mem_req_valid  out  1  fetch request valid.
mem_req_ready  in  1  memory accepts the request.
mem_req_addr  out  XLEN  fetch address, equal to fetch_pc.
mem_rsp_valid  in  1  response valid; responses arrive in order, one per accepted request.
mem_rsp_data  in  XLEN  instruction word.
pc_out  out  XLEN  PC of the instruction sent to decode.
next_pc_out  out  XLEN  pc_out+4.
instruction_out  out  XLEN  instruction word.
valid_out  out  1  decode outputs are valid.

Behaviour:
- State:
  - fetch_pc: next address to request.
  - rsp_pc: PC of the next response to be kept.
  - inflight: accepted requests not yet answered.
  - drop: in-flight responses to discard.
  - FIFO of {pc, instr}, with count.
  - Counter width is $clog2(DEPTH)+1. All PC arithmetic is modulo 2^XLEN; wrap from 0xFFFFFFFC to 0 is allowed.
- Reset (reset==0):
  - fetch_pc and rsp_pc = RESET_VECTOR.
  - inflight, drop and count = 0.
  - valid_out = 0; pc_out, next_pc_out and instruction_out = 0; mem_req_valid = 0.
  - Memory shares the reset, so no responses are pending afterwards.
- Redirect:
  - redirect = trap|mret|branch; priority is trap > mret > branch.
  - On redirect: fetch_pc and rsp_pc <= target; FIFO flushed (count <= 0); drop <= inflight - mem_rsp_valid; valid_out <= 0, regardless of stall.
- Request issue:
  - mem_req_valid = !redirect && (inflight - drop + count) < DEPTH. This is combinational from registered state plus redirect.
  - On an accepted request (valid && ready): inflight += 1 and fetch_pc += 4.
  - mem_req_addr stays stable while valid and not accepted.
- Response (no redirect this cycle):
  - inflight -= 1.
  - If drop > 0: drop -= 1 and the data is discarded.
  - Otherwise: push {rsp_pc, mem_rsp_data} and rsp_pc += 4.
  - An accept and a response in the same cycle leave inflight unchanged.
  - The issue rule guarantees the FIFO never overflows; a push into a full FIFO is a design error and must be asserted.
- Decode output (no redirect this cycle):
  - stall=1: all outputs hold (valid_out included); no pop.
  - stall=0, invalidate=1: valid_out <= 0; no pop; the FIFO head is kept.
  - stall=0, invalidate=0, count>0: pop the head; pc_out <= head.pc; next_pc_out <= head.pc+4; instruction_out <= head.instr; valid_out <= 1.
  - stall=0, invalidate=0, count==0: valid_out <= 0; the other outputs hold.
  - Latency: a response at cycle N into an empty FIFO appears on the outputs at N+2 (push at edge N, pop at edge N+1). There is no bypass.
- Simultaneous push and pop are allowed at any count, including full (pop frees a slot, push uses it) and empty (push only; pop is not possible).
- Freed slots are re-counted for issue from the next cycle.
- Peak throughput is one instruction per cycle when memory has zero wait states.

Test Plan:
- Reset / steady stream: hold reset=0 for 2 cycles, release; memory ready=1 with 1-cycle response -> request addresses 0,4,8,…; valid_out=1 from the 3rd cycle after release, with pc_out 0,4,8 and next_pc_out 4,8,12 on consecutive cycles.
- Backpressure: stall=1 for 10 cycles with DEPTH=4 -> at most 4 requests outstanding or buffered and mem_req_valid drops to 0; outputs frozen; after release, instructions arrive in order with no duplicates or gaps.
- Redirect with stale data: 3 requests in flight, branch=1 with branch_vector=0x100 -> valid_out=0 next cycle; 3 responses discarded; first valid_out=1 shows pc_out=0x100 with the data returned for address 0x100.
- Priority: trap, mret and branch asserted in the same cycle (vectors 0x200/0x300/0x400) -> next request address is 0x200. mret and branch only -> 0x300.
- Invalidate: invalidate=1 for one cycle with count=2 -> valid_out=0 that cycle; the following cycles emit both buffered entries in order.
- Wrap and reset mid-operation: RESET_VECTOR=0xFFFFFFF8 -> request addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0. Assert reset with the FIFO full -> count=0 and valid_out=0 next cycle, and requests restart at RESET_VECTOR.

Source files
------------

// File: rtl/fetch_prefetch.sv
// fetch_prefetch: instruction-fetch stage with a DEPTH-entry prefetch buffer.
//
// The stage issues sequential fetch requests and accepts in-order responses,
// with up to DEPTH requests in flight. Kept responses go into a FIFO of
// {pc, instr}, and one entry per cycle is handed to decode. A redirect (trap,
// mret or branch) flushes the FIFO and marks every in-flight response as
// stale, so those responses are discarded when they arrive.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-low reset
//   branch/trap/mret (+vector) redirect requests; priority trap > mret > branch
//   stall, invalidate          hazard controls for the decode outputs
//   mem_req_valid/ready/addr   fetch request channel
//   mem_rsp_valid/data         in-order fetch responses
//   pc_out, next_pc_out,
//   instruction_out, valid_out registered decode outputs

// Protocol checks on the internal FIFO and in-flight bookkeeping.
module fetch_prefetch_chk #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input logic          clk,
    input logic          reset,
    input logic          w_push,
    input logic          w_pop,
    input logic          mem_rsp_valid,
    input logic [CW-1:0] r_count,
    input logic [CW-1:0] r_inflight,
    input logic [CW-1:0] r_drop
);
    // A push into a full FIFO is only legal when the same edge pops.
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(w_push && !w_pop && (r_count == CW'(DEPTH))))
        else $error("fetch_prefetch: push into full FIFO");

    // Memory must never answer a request that was not issued.
    a_rsp_has_req: assert property (@(posedge clk) disable iff (!reset)
        !(mem_rsp_valid && (r_inflight == {CW{1'b0}})))
        else $error("fetch_prefetch: response with nothing in flight");

    // Stale responses are a subset of the in-flight ones.
    a_drop_bound: assert property (@(posedge clk) disable iff (!reset)
        r_drop <= r_inflight)
        else $error("fetch_prefetch: drop exceeds inflight");
endmodule

module fetch_prefetch #(
    parameter int              XLEN         = 32,
    parameter int              DEPTH        = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            branch,
    input  logic [XLEN-1:0] branch_vector,
    input  logic            trap,
    input  logic            mret,
    input  logic [XLEN-1:0] trap_vector,
    input  logic [XLEN-1:0] mret_vector,
    input  logic            stall,
    input  logic            invalidate,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] next_pc_out,
    output logic [XLEN-1:0] instruction_out,
    output logic            valid_out
);
    localparam int              AW      = $clog2(DEPTH);
    localparam int              CW      = $clog2(DEPTH) + 1;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);
    localparam logic [CW-1:0]   C_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0]   C_ONE   = CW'(1'b1);
    localparam logic [AW-1:0]   P_ONE   = AW'(1'b1);
    localparam logic [CW:0]     OCC_LIM = (CW+1)'(DEPTH);

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_rsp_pc;
    logic [CW-1:0]   r_inflight;
    logic [CW-1:0]   r_drop;
    logic [CW-1:0]   r_count;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr;
    logic [XLEN-1:0] r_fifo_pc    [DEPTH];
    logic [XLEN-1:0] r_fifo_instr [DEPTH];
    logic [XLEN-1:0] r_pc_out;
    logic [XLEN-1:0] r_next_pc_out;
    logic [XLEN-1:0] r_instr_out;
    logic            r_valid_out;

    logic            w_redirect;
    logic [XLEN-1:0] w_target;
    logic [CW:0]     w_occupancy;
    logic            w_req_valid;
    logic            w_accept;
    logic            w_push;
    logic            w_pop;

    // Redirect target selection, trap has highest priority.
    always_comb begin
        w_target = branch_vector;
        if (trap) begin
            w_target = trap_vector;
        end else if (mret) begin
            w_target = mret_vector;
        end else begin
            w_target = branch_vector;
        end
    end

    assign w_redirect = trap | mret | branch;

    // Slots already claimed: live in-flight requests plus buffered entries.
    // Stale requests do not count because their data will never be pushed.
    assign w_occupancy = {1'b0, r_inflight} - {1'b0, r_drop} + {1'b0, r_count};
    assign w_req_valid = reset && !w_redirect && (w_occupancy < OCC_LIM);
    assign w_accept    = w_req_valid && mem_req_ready;
    assign w_push      = !w_redirect && mem_rsp_valid && (r_drop == C_ZERO);
    assign w_pop       = !w_redirect && !stall && !invalidate && (r_count != C_ZERO);

    // Fetch/response PCs, in-flight and stale counters, FIFO pointers and count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_fetch_pc <= RESET_VECTOR;
            r_rsp_pc   <= RESET_VECTOR;
            r_inflight <= C_ZERO;
            r_drop     <= C_ZERO;
            r_count    <= C_ZERO;
            r_rd_ptr   <= {AW{1'b0}};
            r_wr_ptr   <= {AW{1'b0}};
        end else begin
            // No request is accepted during a redirect, so this covers both cases.
            r_inflight <= r_inflight + (w_accept ? C_ONE : C_ZERO)
                                     - (mem_rsp_valid ? C_ONE : C_ZERO);
            if (w_redirect) begin
                r_fetch_pc <= w_target;
                r_rsp_pc   <= w_target;
                r_drop     <= r_inflight - (mem_rsp_valid ? C_ONE : C_ZERO);
                r_count    <= C_ZERO;
                r_rd_ptr   <= {AW{1'b0}};
                r_wr_ptr   <= {AW{1'b0}};
            end else begin
                if (w_accept) begin
                    r_fetch_pc <= r_fetch_pc + PC_STEP;
                end
                if (mem_rsp_valid && (r_drop != C_ZERO)) begin
                    r_drop <= r_drop - C_ONE;
                end
                if (w_push) begin
                    r_rsp_pc <= r_rsp_pc + PC_STEP;
                    r_wr_ptr <= r_wr_ptr + P_ONE;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + P_ONE;
                end
                r_count <= r_count + (w_push ? C_ONE : C_ZERO) - (w_pop ? C_ONE : C_ZERO);
            end
        end
    end

    // FIFO storage; a full-FIFO push+pop reads the old head before it is overwritten.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]    <= r_rsp_pc;
            r_fifo_instr[r_wr_ptr] <= mem_rsp_data;
        end
    end

    // Decode output register: redirect bubbles, stall holds, otherwise pop or bubble.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid_out   <= 1'b0;
            r_pc_out      <= {XLEN{1'b0}};
            r_next_pc_out <= {XLEN{1'b0}};
            r_instr_out   <= {XLEN{1'b0}};
        end else if (w_redirect) begin
            r_valid_out <= 1'b0;
        end else if (!stall) begin
            if (w_pop) begin
                r_valid_out   <= 1'b1;
                r_pc_out      <= r_fifo_pc[r_rd_ptr];
                r_next_pc_out <= r_fifo_pc[r_rd_ptr] + PC_STEP;
                r_instr_out   <= r_fifo_instr[r_rd_ptr];
            end else begin
                r_valid_out <= 1'b0;
            end
        end
    end

    assign mem_req_valid   = w_req_valid;
    assign mem_req_addr    = r_fetch_pc;
    assign pc_out          = r_pc_out;
    assign next_pc_out     = r_next_pc_out;
    assign instruction_out = r_instr_out;
    assign valid_out       = r_valid_out;

    fetch_prefetch_chk #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_chk (
        .clk           (clk),
        .reset         (reset),
        .w_push        (w_push),
        .w_pop         (w_pop),
        .mem_rsp_valid (mem_rsp_valid),
        .r_count       (r_count),
        .r_inflight    (r_inflight),
        .r_drop        (r_drop)
    );
endmodule

// File: tb/tb_fetch_prefetch.sv
// Testbench for fetch_prefetch: queue-based reference model plus memory model,
// hand-written corner-case sequences, a priority vector table and a random phase.
module tb_fetch_prefetch;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RV    = 32'h0000_0000;
    localparam logic [31:0] RV_W  = 32'hFFFF_FFF8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, branch, trap, mret, stall, invalidate;
    logic [31:0] branch_vector, trap_vector, mret_vector;
    logic        mem_req_valid, mem_req_ready, mem_rsp_valid;
    logic [31:0] mem_req_addr, mem_rsp_data;
    logic [31:0] pc_out, next_pc_out, instruction_out;
    logic        valid_out;

    // Second instance: wrap-around reset vector, memory never answers.
    logic        w_req_valid, w_valid_out;
    logic [31:0] w_req_addr, w_pc_out, w_npc_out, w_instr_out;

    fetch_prefetch #(.XLEN(32), .DEPTH(DEPTH), .RESET_VECTOR(RV)) dut (
        .clk(clk), .reset(reset), .branch(branch), .branch_vector(branch_vector),
        .trap(trap), .mret(mret), .trap_vector(trap_vector), .mret_vector(mret_vector),
        .stall(stall), .invalidate(invalidate),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .pc_out(pc_out), .next_pc_out(next_pc_out), .instruction_out(instruction_out),
        .valid_out(valid_out)
    );

    fetch_prefetch #(.XLEN(32), .DEPTH(DEPTH), .RESET_VECTOR(RV_W)) dut_w (
        .clk(clk), .reset(reset), .branch(1'b0), .branch_vector(32'h0),
        .trap(1'b0), .mret(1'b0), .trap_vector(32'h0), .mret_vector(32'h0),
        .stall(1'b0), .invalidate(1'b0),
        .mem_req_valid(w_req_valid), .mem_req_ready(1'b1), .mem_req_addr(w_req_addr),
        .mem_rsp_valid(1'b0), .mem_rsp_data(32'h0),
        .pc_out(w_pc_out), .next_pc_out(w_npc_out), .instruction_out(w_instr_out),
        .valid_out(w_valid_out)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %b required %b at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction word stored at an address (odd multiplier => distinct per address).
    function automatic logic [31:0] mdata(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Memory model: in-order queue of accepted addresses with a due cycle.
    typedef struct { logic [31:0] addr; int due; } mreq_t;
    mreq_t mem_q[$];
    int    cyc     = 0;
    int    lat_min = 1;
    int    lat_max = 1;
    bit    rand_rdy = 1'b0;

    // Reference model: in-flight PCs with a stale flag, FIFO of buffered PCs.
    typedef struct { logic [31:0] pc; bit stale; } infl_t;
    infl_t       m_infl[$];
    logic [31:0] m_fifo[$];
    logic [31:0] m_fetch_pc, m_pc, m_npc, m_instr;
    logic        m_valid;

    function automatic int m_occ();
        int n = 0;
        foreach (m_infl[i]) if (!m_infl[i].stale) n++;
        return n + m_fifo.size();
    endfunction

    // One clock cycle: drive memory, check the request channel, step the model,
    // then check decode outputs on the falling edge.
    task automatic tick();
        logic        rsp, redir, exp_rv, acc, keep;
        logic [31:0] rsp_addr, tgt, acc_addr, kpc;
        infl_t       h;
        int          lat;
        rsp = 1'b0; rsp_addr = 32'h0; keep = 1'b0; kpc = 32'h0;
        if (reset && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            rsp = 1'b1;
            rsp_addr = mem_q[0].addr;
        end
        mem_rsp_valid = rsp;
        mem_rsp_data  = rsp ? mdata(rsp_addr) : 32'hDEAD_BEEF;
        if (rand_rdy) mem_req_ready = ($urandom_range(0, 99) < 70);
        #1;
        redir  = trap | mret | branch;
        tgt    = trap ? trap_vector : (mret ? mret_vector : branch_vector);
        exp_rv = reset && !redir && (m_occ() < DEPTH);
        chk1("req_valid", mem_req_valid, exp_rv);
        if (exp_rv) chk("req_addr", mem_req_addr, m_fetch_pc);
        acc      = mem_req_valid && mem_req_ready;
        acc_addr = mem_req_addr;
        lat      = $urandom_range(lat_min, lat_max);
        @(posedge clk);
        if (!reset) begin
            mem_q.delete();
        end else begin
            if (rsp) void'(mem_q.pop_front());
            if (acc) mem_q.push_back('{acc_addr, cyc + lat});
        end
        if (!reset) begin
            m_infl.delete();
            m_fifo.delete();
            m_fetch_pc = RV;
            m_valid = 1'b0; m_pc = 32'h0; m_npc = 32'h0; m_instr = 32'h0;
        end else begin
            if (rsp && m_infl.size() > 0) begin
                h    = m_infl.pop_front();
                keep = !h.stale && !redir;
                kpc  = h.pc;
            end
            if (redir) begin
                foreach (m_infl[i]) m_infl[i].stale = 1'b1;
                m_fifo.delete();
                m_fetch_pc = tgt;
                m_valid = 1'b0;
            end else begin
                if (exp_rv && mem_req_ready) begin
                    m_infl.push_back('{m_fetch_pc, 1'b0});
                    m_fetch_pc = m_fetch_pc + 32'd4;
                end
                if (!stall) begin
                    if (!invalidate && m_fifo.size() > 0) begin
                        m_pc    = m_fifo.pop_front();
                        m_npc   = m_pc + 32'd4;
                        m_instr = mdata(m_pc);
                        m_valid = 1'b1;
                    end else begin
                        m_valid = 1'b0;
                    end
                end
                if (keep) m_fifo.push_back(kpc);
            end
        end
        cyc++;
        @(negedge clk);
        chk1("valid_out", valid_out, m_valid);
        chk("pc_out", pc_out, m_pc);
        chk("next_pc_out", next_pc_out, m_npc);
        chk("instruction_out", instruction_out, m_instr);
    endtask

    task automatic idle_inputs();
        branch = 1'b0; trap = 1'b0; mret = 1'b0; stall = 1'b0; invalidate = 1'b0;
        branch_vector = 32'h0; trap_vector = 32'h0; mret_vector = 32'h0;
        mem_req_ready = 1'b1; rand_rdy = 1'b0; lat_min = 1; lat_max = 1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    typedef struct { logic t; logic m; logic b; logic [31:0] exp_addr; } prio_t;
    prio_t       prio_tab[6];
    logic [31:0] w_exp_addr[4];
    logic        st_valid[6];
    logic [31:0] st_pc[6];

    initial begin
        logic [31:0] exp_pc;
        int          n_emit;
        bit          found;

        prio_tab[0] = '{1'b1, 1'b1, 1'b1, 32'h0000_0200};
        prio_tab[1] = '{1'b0, 1'b1, 1'b1, 32'h0000_0300};
        prio_tab[2] = '{1'b0, 1'b0, 1'b1, 32'h0000_0400};
        prio_tab[3] = '{1'b1, 1'b0, 1'b1, 32'h0000_0200};
        prio_tab[4] = '{1'b0, 1'b1, 1'b0, 32'h0000_0300};
        prio_tab[5] = '{1'b1, 1'b0, 1'b0, 32'h0000_0200};
        w_exp_addr[0] = 32'hFFFF_FFF8; w_exp_addr[1] = 32'hFFFF_FFFC;
        w_exp_addr[2] = 32'h0000_0000; w_exp_addr[3] = 32'h0000_0004;
        st_valid[1] = 1'b0; st_valid[2] = 1'b0; st_valid[3] = 1'b1;
        st_valid[4] = 1'b1; st_valid[5] = 1'b1;
        st_pc[3] = 32'h0; st_pc[4] = 32'h4; st_pc[5] = 32'h8;
        st_valid[0] = 1'b0; st_pc[0] = 32'h0; st_pc[1] = 32'h0; st_pc[2] = 32'h0;
        mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0;

        // Reset state and steady stream (also the wrap-around instance).
        idle_inputs();
        reset = 1'b0;
        tick();
        chk1("rst_valid_out", valid_out, 1'b0);
        chk("rst_pc_out", pc_out, 32'h0);
        chk("rst_instr_out", instruction_out, 32'h0);
        chk1("rst_req_valid", mem_req_valid, 1'b0);
        tick();
        reset = 1'b1;
        #1;
        chk1("wrap_req_valid0", w_req_valid, 1'b1);
        chk("wrap_req_addr0", w_req_addr, w_exp_addr[0]);
        chk("steady_req_addr0", mem_req_addr, RV);
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk1("steady_valid", valid_out, st_valid[k]);
            if (st_valid[k]) begin
                chk("steady_pc", pc_out, st_pc[k]);
                chk("steady_npc", next_pc_out, st_pc[k] + 32'd4);
                chk("steady_instr", instruction_out, mdata(st_pc[k]));
            end
            if (k <= 3) begin
                chk1("wrap_req_valid", w_req_valid, 1'b1);
                chk("wrap_req_addr", w_req_addr, w_exp_addr[k]);
            end else begin
                chk1("wrap_req_full", w_req_valid, 1'b0);
            end
        end

        // Backpressure: outputs frozen, request channel closes when full.
        stall = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk1("bp_valid_held", valid_out, 1'b1);
            chk("bp_pc_held", pc_out, 32'h8);
        end
        #1;
        chk1("bp_req_closed", mem_req_valid, 1'b0);
        stall = 1'b0;
        exp_pc = 32'hC;
        n_emit = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (valid_out) begin
                chk("bp_order", pc_out, exp_pc);
                exp_pc = exp_pc + 32'd4;
                n_emit++;
            end
        end
        chk1("bp_throughput", n_emit >= 8, 1'b1);

        // Redirect with three stale responses in flight.
        do_reset();
        lat_min = 5; lat_max = 5;
        tick(); tick(); tick();
        branch = 1'b1; branch_vector = 32'h0000_0100;
        tick();
        branch = 1'b0;
        chk1("redir_bubble", valid_out, 1'b0);
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            tick();
            if (valid_out) found = 1'b1;
        end
        chk1("redir_seen", found, 1'b1);
        if (found) begin
            chk("redir_pc", pc_out, 32'h0000_0100);
            chk("redir_instr", instruction_out, mdata(32'h0000_0100));
        end

        // Redirect priority table.
        do_reset();
        trap_vector = 32'h200; mret_vector = 32'h300; branch_vector = 32'h400;
        for (int k = 0; k < 6; k++) begin
            trap = prio_tab[k].t; mret = prio_tab[k].m; branch = prio_tab[k].b;
            tick();
            trap = 1'b0; mret = 1'b0; branch = 1'b0;
            #1;
            chk1("prio_req_valid", mem_req_valid, 1'b1);
            chk("prio_req_addr", mem_req_addr, prio_tab[k].exp_addr);
        end

        // Invalidate with two buffered entries.
        do_reset();
        stall = 1'b1;
        tick(); tick();
        mem_req_ready = 1'b0;
        tick();
        stall = 1'b0; invalidate = 1'b1;
        tick();
        chk1("inv_bubble", valid_out, 1'b0);
        invalidate = 1'b0;
        tick();
        chk1("inv_first_valid", valid_out, 1'b1);
        chk("inv_first_pc", pc_out, 32'h0);
        chk("inv_first_instr", instruction_out, mdata(32'h0));
        tick();
        chk1("inv_second_valid", valid_out, 1'b1);
        chk("inv_second_pc", pc_out, 32'h4);
        tick();
        chk1("inv_drained", valid_out, 1'b0);

        // Reset with the FIFO full.
        do_reset();
        for (int k = 0; k < 4; k++) tick();
        stall = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        #1;
        chk1("full_req_closed", mem_req_valid, 1'b0);
        chk1("full_valid_held", valid_out, 1'b1);
        reset = 1'b0;
        tick();
        chk1("midrst_valid", valid_out, 1'b0);
        chk("midrst_pc", pc_out, 32'h0);
        reset = 1'b1; stall = 1'b0;
        #1;
        chk1("midrst_req_valid", mem_req_valid, 1'b1);
        chk("midrst_req_addr", mem_req_addr, RV);
        tick();
        chk1("midrst_no_stale_pop", valid_out, 1'b0);

        // Random phase against the reference model.
        do_reset();
        rand_rdy = 1'b1; lat_min = 1; lat_max = 4;
        for (int k = 0; k < 3000; k++) begin
            stall         = ($urandom_range(0, 99) < 20);
            invalidate    = ($urandom_range(0, 99) < 10);
            branch        = ($urandom_range(0, 99) < 5);
            trap          = ($urandom_range(0, 99) < 2);
            mret          = ($urandom_range(0, 99) < 2);
            branch_vector = $urandom() & 32'hFFFF_FFFC;
            trap_vector   = $urandom() & 32'hFFFF_FFFC;
            mret_vector   = 32'hFFFF_FFF0 | ($urandom() & 32'h0000_000C);
            reset         = ($urandom_range(0, 499) != 0);
            tick();
        end

        // The wrap instance never got data, so its decode side stays idle.
        chk1("wrap_valid_out", w_valid_out, 1'b0);
        chk("wrap_pc_out", w_pc_out, 32'h0);
        chk("wrap_npc_out", w_npc_out, 32'h0);
        chk("wrap_instr_out", w_instr_out, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
